// File: rtl/bus_uart_pkg.sv
// ============================================================================
// bus_uart_pkg : shared state encodings and err-vector bit indices
// Rev 1.0
// ============================================================================
`default_nettype none

package bus_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam int ERR_TX_OVF = 0;
  localparam int ERR_RX_OVF = 1;
  localparam int ERR_FRAME  = 2;

  function automatic logic even_par(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bus_uart_fifo.sv
// ============================================================================
// bus_uart_fifo : byte FIFO with extra-MSB pointers, head visible combinationally
// Rev 1.0
// ============================================================================
`default_nettype none

module bus_uart_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  // A pop frees the slot a simultaneous push into a full FIFO lands in.
  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

`default_nettype wire

// File: rtl/bus_uart.sv
// ============================================================================
// bus_uart : P874x external-bus UART, TX/RX FIFOs, sticky errors, T1/INTb status
// Optional even parity when BUS_UART_PARITY_EN is defined (8E1), else 8N1.
// Rev 1.0
// ============================================================================
`default_nettype none

module bus_uart
  import bus_uart_pkg::*;
#(
  parameter int CLK_DIV    = 104,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wrb,
  input  logic       db_oeb,
  input  logic [7:0] db_wdata,
  input  logic       rdb,
  output logic [7:0] db_rdata,
  input  logic       rxd,
  output logic       txd,
  output logic       rx_nempty,
  output logic       intb,
  output logic       tx_full,
  input  logic       err_clr,
  output logic [2:0] err
);

  localparam int             CW       = $clog2(CLK_DIV);
  localparam logic [CW-1:0]  CNT_FULL = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0]  CNT_HALF = CW'(CLK_DIV / 2 - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

  logic       tx_push, tx_pop, tx_empty;
  logic [7:0] tx_head;
  logic       rx_push, rx_pop, rx_empty, rx_full;
  logic [7:0] rx_head;

  uart_state_e   tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_byte_q, tx_byte_d;
  logic          txd_q, txd_d;

  uart_state_e   rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic          rxd_meta_q, rxd_sync_q, rxd_prev_q;
  logic          rx_par_bad, rx_frame_set;

  logic [2:0]    err_q, err_d, err_set;
  logic          rx_nempty_q;

  assign tx_push   = !wrb && !db_oeb;
  assign rx_pop    = !rdb;
  assign db_rdata  = rx_empty ? 8'hFF : rx_head;
  assign txd       = txd_q;
  assign rx_nempty = rx_nempty_q;
  assign intb      = ~rx_nempty_q;
  assign err       = err_q;

  bus_uart_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(tx_push), .pop(tx_pop), .wdata(db_wdata),
    .head(tx_head), .full(tx_full), .empty(tx_empty)
  );

  bus_uart_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(rx_push), .pop(rx_pop), .wdata(rx_shift_q),
    .head(rx_head), .full(rx_full), .empty(rx_empty)
  );

  // TX: txd is registered, so it drops on the same edge the byte leaves the FIFO.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_byte_d  = tx_byte_q;
    txd_d      = txd_q;
    tx_pop     = 1'b0;
    case (tx_state_q)
      ST_IDLE: begin
        txd_d = 1'b1;
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_byte_d  = tx_head;
          tx_cnt_d   = CNT_FULL;
          tx_bit_d   = 3'd0;
          txd_d      = 1'b0;
          tx_state_d = ST_START;
        end
      end
      ST_START: begin
        tx_cnt_d = tx_cnt_q - CNT_ONE;
        if (tx_cnt_q == '0) begin
          tx_cnt_d   = CNT_FULL;
          txd_d      = tx_byte_q[0];
          tx_state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        tx_cnt_d = tx_cnt_q - CNT_ONE;
        if (tx_cnt_q == '0) begin
          tx_cnt_d = CNT_FULL;
          if (tx_bit_q == 3'd7) begin
`ifdef BUS_UART_PARITY_EN
            txd_d      = even_par(tx_byte_q);
            tx_state_d = ST_PARITY;
`else
            txd_d      = 1'b1;
            tx_state_d = ST_STOP;
`endif
          end else begin
            tx_bit_d = tx_bit_q + 3'd1;
            txd_d    = tx_byte_q[tx_bit_d];
          end
        end
      end
`ifdef BUS_UART_PARITY_EN
      ST_PARITY: begin
        tx_cnt_d = tx_cnt_q - CNT_ONE;
        if (tx_cnt_q == '0) begin
          tx_cnt_d   = CNT_FULL;
          txd_d      = 1'b1;
          tx_state_d = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        tx_cnt_d = tx_cnt_q - CNT_ONE;
        if (tx_cnt_q == '0) tx_state_d = ST_IDLE;
      end
      default: begin
        txd_d      = 1'b1;
        tx_state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_q <= ST_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_byte_q  <= '0;
      txd_q      <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_byte_q  <= tx_byte_d;
      txd_q      <= txd_d;
    end
  end

`ifdef BUS_UART_PARITY_EN
  logic rx_par_err_q, rx_par_err_d;
  assign rx_par_bad = rx_par_err_q;
`else
  assign rx_par_bad = 1'b0;
`endif

  // RX: a low STOP leaves rxd_prev low, so re-arming needs the line to rise first.
  always_comb begin
    rx_state_d   = rx_state_q;
    rx_cnt_d     = rx_cnt_q;
    rx_bit_d     = rx_bit_q;
    rx_shift_d   = rx_shift_q;
    rx_push      = 1'b0;
    rx_frame_set = 1'b0;
`ifdef BUS_UART_PARITY_EN
    rx_par_err_d = rx_par_err_q;
`endif
    case (rx_state_q)
      ST_IDLE: begin
        if (rxd_prev_q && !rxd_sync_q) begin
          rx_cnt_d   = CNT_HALF;
          rx_state_d = ST_START;
        end
      end
      ST_START: begin
        rx_cnt_d = rx_cnt_q - CNT_ONE;
        if (rx_cnt_q == '0) begin
          rx_cnt_d   = CNT_FULL;
          rx_bit_d   = 3'd0;
          rx_state_d = rxd_sync_q ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        rx_cnt_d = rx_cnt_q - CNT_ONE;
        if (rx_cnt_q == '0) begin
          rx_cnt_d   = CNT_FULL;
          rx_shift_d = {rxd_sync_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) begin
`ifdef BUS_UART_PARITY_EN
            rx_state_d = ST_PARITY;
`else
            rx_state_d = ST_STOP;
`endif
          end
        end
      end
`ifdef BUS_UART_PARITY_EN
      ST_PARITY: begin
        rx_cnt_d = rx_cnt_q - CNT_ONE;
        if (rx_cnt_q == '0) begin
          rx_cnt_d     = CNT_FULL;
          rx_par_err_d = rxd_sync_q ^ even_par(rx_shift_q);
          rx_state_d   = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        rx_cnt_d = rx_cnt_q - CNT_ONE;
        if (rx_cnt_q == '0) begin
          rx_state_d = ST_IDLE;
          if (rxd_sync_q && !rx_par_bad) rx_push      = 1'b1;
          else                           rx_frame_set = 1'b1;
        end
      end
      default: rx_state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state_q   <= ST_IDLE;
      rx_cnt_q     <= '0;
      rx_bit_q     <= '0;
      rx_shift_q   <= '0;
      rxd_meta_q   <= 1'b1;
      rxd_sync_q   <= 1'b1;
      rxd_prev_q   <= 1'b1;
`ifdef BUS_UART_PARITY_EN
      rx_par_err_q <= 1'b0;
`endif
    end else begin
      rx_state_q   <= rx_state_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_bit_q     <= rx_bit_d;
      rx_shift_q   <= rx_shift_d;
      rxd_meta_q   <= rxd;
      rxd_sync_q   <= rxd_meta_q;
      rxd_prev_q   <= rxd_sync_q;
`ifdef BUS_UART_PARITY_EN
      rx_par_err_q <= rx_par_err_d;
`endif
    end
  end

  // A new error in the err_clr cycle still sticks.
  always_comb begin
    err_set             = '0;
    err_set[ERR_TX_OVF] = tx_push && tx_full && !tx_pop;
    err_set[ERR_RX_OVF] = rx_push && rx_full && !(rx_pop && !rx_empty);
    err_set[ERR_FRAME]  = rx_frame_set;
    err_d               = (err_clr ? 3'b000 : err_q) | err_set;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q       <= '0;
      rx_nempty_q <= 1'b0;
    end else begin
      err_q       <= err_d;
      rx_nempty_q <= !rx_empty;
    end
  end

endmodule

`default_nettype wire
